// File: rtl/mealy_seq_det.sv
`default_nettype none
// ============================================================================
//  Module      : mealy_seq_det
//  Description : Parametrised Mealy serial sequence detector with KMP-style
//                fallback, overlapping / non-overlapping detection and a
//                saturating match counter.
//  Ports       : clk        - system clock, rising edge
//                rst        - synchronous active-high reset
//                en         - bit-valid qualifier for din
//                din        - serial data bit (PATTERN[PAT_LEN-1] arrives first)
//                clr_cnt    - synchronous clear of match_cnt
//                match      - pattern-complete indication
//                match_cnt  - saturating count of matches
//                prog       - matched-prefix length k (debug)
//  Options     : MEALY_SEQ_DET_MATCH_REG_EN - when defined, match is
//                registered and appears one cycle after the final bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module mealy_seq_det #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       din,
    input  logic                       clr_cnt,
    output logic                       match,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [$clog2(PAT_LEN)-1:0] prog
);

    localparam int KW    = $clog2(PAT_LEN);
    localparam int TBL_N = 2 ** (KW + 1);

    localparam logic [KW-1:0]    c_K_LAST  = KW'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // Next state for (k, b). Because k is the longest suffix of the history
    // that is a pattern prefix, the last k bits of history are exactly
    // PATTERN's first k bits, so the next state depends only on k and b.
    // The search is capped at PAT_LEN-1, which turns a full match into the
    // longest proper border (overlapping restart).
    function automatic int f_next(input int k, input bit b);
        bit [15:0] v_pat;
        bit [15:0] v_str;
        int        v_best;
        int        v_idx;
        int        v_pi;
        bit        v_ok;
        v_pat  = 16'(PATTERN);
        v_str  = '0;
        v_best = 0;
        for (int i = 0; i < PAT_LEN; i++) begin
            v_pi = PAT_LEN - 1 - i;
            if (i < k) begin
                v_str[i[3:0]] = v_pat[v_pi[3:0]];
            end else if (i == k) begin
                v_str[i[3:0]] = b;
            end
        end
        if ((k == PAT_LEN - 1) && (b == v_pat[0]) && !OVERLAP) begin
            return 0;
        end
        for (int j = 1; j < PAT_LEN; j++) begin
            if (j <= k + 1) begin
                v_ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    v_idx = k + 1 - j + i;
                    v_pi  = PAT_LEN - 1 - i;
                    if (v_pat[v_pi[3:0]] != v_str[v_idx[3:0]]) begin
                        v_ok = 1'b0;
                    end
                end
                if (v_ok) begin
                    v_best = j;
                end
            end
        end
        return v_best;
    endfunction

    logic [KW-1:0]    r_k;
    logic [CNT_W-1:0] r_cnt;
    logic [KW-1:0]    w_nxt_tbl [TBL_N];
    logic             w_legal;
    logic             w_hit;

    // Transition table indexed by {k, b}; encodings k >= PAT_LEN map to 0.
    for (genvar gi = 0; gi < TBL_N; gi++) begin : g_tbl
        if ((gi / 2) < PAT_LEN) begin : g_legal_ent
            assign w_nxt_tbl[gi] = KW'(f_next(gi / 2, bit'(gi % 2)));
        end else begin : g_illegal_ent
            assign w_nxt_tbl[gi] = '0;
        end
    end

    // When PAT_LEN is a power of two every encoding of k is legal.
    if (PAT_LEN == (2 ** KW)) begin : g_legal_full
        assign w_legal = 1'b1;
    end else begin : g_legal_chk
        assign w_legal = (r_k <= c_K_LAST);
    end

    assign w_hit = en & ~rst & (r_k == c_K_LAST) & (din == PATTERN[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k   <= '0;
            r_cnt <= '0;
        end else begin
            if (!w_legal) begin
                r_k <= '0;
            end else if (en) begin
                r_k <= w_nxt_tbl[{r_k, din}];
            end

            // A clear wins over an increment in the same cycle.
            if (clr_cnt) begin
                r_cnt <= '0;
            end else if (w_hit && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef MEALY_SEQ_DET_MATCH_REG_EN
    logic r_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_match <= 1'b0;
        end else begin
            r_match <= w_hit;
        end
    end

    assign match = r_match;
`else
    assign match = w_hit;
`endif

    assign match_cnt = r_cnt;
    assign prog      = r_k;

endmodule
`default_nettype wire

// File: tb/tb_mealy_seq_det.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mealy_seq_det
//  Description : Self-checking bench for mealy_seq_det. Three instances
//                (overlapping, non-overlapping, 2-bit counter) share the
//                stimulus; each step names the instance it checks.
//  Options     : MEALY_SEQ_DET_MATCH_REG_EN - expects match one cycle late.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mealy_seq_det;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic din;
    logic clr_cnt;

    logic       m_a, m_b, m_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic [1:0] prog_a, prog_b, prog_c;

    always #5 clk = ~clk;

    mealy_seq_det #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
        .match(m_a), .match_cnt(cnt_a), .prog(prog_a)
    );

    mealy_seq_det #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
        .match(m_b), .match_cnt(cnt_b), .prog(prog_b)
    );

    mealy_seq_det #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
        .match(m_c), .match_cnt(cnt_c), .prog(prog_c)
    );

    typedef struct {
        int         id;
        string      tag;
        logic       m;
        logic [7:0] cnt;
        logic [1:0] prog;
        bit         chk;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic prev_m   = 1'b0;

    // One cycle of stimulus; cnt/pg are the values expected before this
    // cycle's clock edge, m is the combinational match for this cycle.
    task automatic step(input int id, input string tag, input logic r, input logic e,
                        input logic d, input logic c, input logic m, input int cnt,
                        input int pg, input bit chk);
        exp_t x;
        @(posedge clk);
        #1;
        rst     = r;
        en      = e;
        din     = d;
        clr_cnt = c;
        x.id  = id;
        x.tag = tag;
`ifdef MEALY_SEQ_DET_MATCH_REG_EN
        x.m    = prev_m;
        prev_m = m;
`else
        x.m    = m;
`endif
        x.cnt  = 8'(cnt);
        x.prog = 2'(pg);
        x.chk  = chk;
        q.push_back(x);
    endtask

    task automatic rs(input int id, input string tag);
        step(id, tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic b(input int id, input string tag, input logic d, input logic m,
                     input int cnt, input int pg);
        step(id, tag, 1'b0, 1'b1, d, 1'b0, m, cnt, pg, 1'b1);
    endtask

    task automatic g(input int id, input string tag, input logic d, input int cnt, input int pg);
        step(id, tag, 1'b0, 1'b0, d, 1'b0, 1'b0, cnt, pg, 1'b1);
    endtask

    // Monitor: pops one expectation per cycle and compares mid-cycle.
    always @(negedge clk) begin : mon
        exp_t       x;
        logic       am;
        logic [7:0] ac;
        logic [1:0] ap;
        if (q.size() > 0) begin
            x = q.pop_front();
            case (x.id)
                0:       begin am = m_a; ac = cnt_a;         ap = prog_a; end
                1:       begin am = m_b; ac = cnt_b;         ap = prog_b; end
                default: begin am = m_c; ac = {6'd0, cnt_c}; ap = prog_c; end
            endcase
            checks++;
            if (am !== x.m) begin
                failures++;
                $display("FAIL %s match: got %b expected %b", x.tag, am, x.m);
            end
            if (x.chk) begin
                checks++;
                if (ac !== x.cnt) begin
                    failures++;
                    $display("FAIL %s match_cnt: got %0d expected %0d", x.tag, ac, x.cnt);
                end
                checks++;
                if (ap !== x.prog) begin
                    failures++;
                    $display("FAIL %s prog: got %0d expected %0d", x.tag, ap, x.prog);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; en = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        repeat (3) @(posedge clk);

        // Overlapping detection and KMP fallbacks
        rs(0, "s1_rst");
        b(0, "s1_b1", 1, 0, 0, 0); b(0, "s1_b2", 0, 0, 0, 1);
        b(0, "s1_b3", 1, 0, 0, 2); b(0, "s1_b4", 1, 1, 0, 3);
        b(0, "s1_b5", 0, 0, 1, 1); b(0, "s1_b6", 1, 0, 1, 2);
        b(0, "s1_b7", 1, 1, 1, 3); g(0, "s1_idle", 0, 2, 1);
        b(0, "s1_f1", 1, 0, 2, 1); b(0, "s1_f2", 0, 0, 2, 1);
        b(0, "s1_f3", 0, 0, 2, 2); b(0, "s1_f4", 1, 0, 2, 0);
        b(0, "s1_f5", 0, 0, 2, 1); b(0, "s1_f6", 1, 0, 2, 2);
        b(0, "s1_f7", 0, 0, 2, 3); g(0, "s1_end", 0, 2, 2);

        // Non-overlapping detection
        rs(1, "s2_rst");
        b(1, "s2_b1", 1, 0, 0, 0); b(1, "s2_b2", 0, 0, 0, 1);
        b(1, "s2_b3", 1, 0, 0, 2); b(1, "s2_b4", 1, 1, 0, 3);
        b(1, "s2_b5", 0, 0, 1, 0); b(1, "s2_b6", 1, 0, 1, 0);
        b(1, "s2_b7", 1, 0, 1, 1); g(1, "s2_idle", 0, 1, 1);
        rs(1, "s2b_rst");
        b(1, "s2b_b1", 1, 0, 0, 0); b(1, "s2b_b2", 0, 0, 0, 1);
        b(1, "s2b_b3", 1, 0, 0, 2); b(1, "s2b_b4", 1, 1, 0, 3);
        b(1, "s2b_b5", 1, 0, 1, 0); b(1, "s2b_b6", 0, 0, 1, 1);
        b(1, "s2b_b7", 1, 0, 1, 2); b(1, "s2b_b8", 1, 1, 1, 3);
        g(1, "s2b_end", 0, 2, 0);

        // Enable gaps, including a gap at k=3 with the final bit value
        rs(0, "s3_rst");
        b(0, "s3_b1", 1, 0, 0, 0); g(0, "s3_g1", 0, 0, 1);
        b(0, "s3_b2", 0, 0, 0, 1); g(0, "s3_g2", 1, 0, 2);
        b(0, "s3_b3", 1, 0, 0, 2); g(0, "s3_g3", 1, 0, 3);
        b(0, "s3_b4", 1, 1, 0, 3); g(0, "s3_end", 0, 1, 1);

        // Reset mid-pattern, with en=1 and the completing bit present
        rs(0, "s4_rst");
        b(0, "s4_b1", 1, 0, 0, 0); b(0, "s4_b2", 0, 0, 0, 1);
        b(0, "s4_b3", 1, 0, 0, 2);
        step(0, "s4_midrst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 3, 1'b1);
        b(0, "s4_b4", 1, 0, 0, 0); g(0, "s4_end", 0, 0, 1);

        // Saturation at 3 with a 2-bit counter, then clear in a match cycle
        rs(2, "s5_rst");
        b(2, "s5_b1", 1, 0, 0, 0);  b(2, "s5_b2", 0, 0, 0, 1);
        b(2, "s5_b3", 1, 0, 0, 2);  b(2, "s5_b4", 1, 1, 0, 3);
        b(2, "s5_b5", 0, 0, 1, 1);  b(2, "s5_b6", 1, 0, 1, 2);
        b(2, "s5_b7", 1, 1, 1, 3);  b(2, "s5_b8", 0, 0, 2, 1);
        b(2, "s5_b9", 1, 0, 2, 2);  b(2, "s5_b10", 1, 1, 2, 3);
        b(2, "s5_b11", 0, 0, 3, 1); b(2, "s5_b12", 1, 0, 3, 2);
        b(2, "s5_b13", 1, 1, 3, 3); b(2, "s5_b14", 0, 0, 3, 1);
        b(2, "s5_b15", 1, 0, 3, 2);
        step(2, "s5_clr", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3, 3, 1'b1);
        g(2, "s5_end", 0, 0, 1);

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mealy_seq_det.md
Name: mealy_seq_det

Overview:
Parametrised Mealy sequence detector. It is the successor to the team's fixed 3-state Mealy FSM.
- Detects an arbitrary PAT_LEN-bit serial pattern on din, one bit per enabled cycle.
- Supports overlapping and non-overlapping detection.
- Keeps a saturating match counter.
- Sits after the serial input synchroniser in the lab datapath and feeds the status/LED logic.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..16.
PATTERN, 4'b1011, target pattern; bit [PAT_LEN-1] is the first bit received.
OVERLAP, 1, 1 = overlapping detection, 0 = non-overlapping.
CNT_W, 8, width of match_cnt.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  bit-valid qualifier; din is consumed only when en=1.
din  input  1  serial data bit.
clr_cnt  input  1  synchronous clear of match_cnt.
match  output  1  pattern-complete indication.
match_cnt  output  CNT_W  number of matches detected, saturating.
prog  output  $clog2(PAT_LEN)  current state k, i.e. matched-prefix length (debug).

Behaviour:
- Reset is synchronous, active-high, and sampled on the clk rising edge. When rst=1:
  - k <= 0 and match_cnt <= 0.
  - match=0 in that cycle, regardless of din/en.
  - rst has priority over en and clr_cnt.
  - Reset mid-pattern discards all partial progress.
- State definition: k in 0..PAT_LEN-1 is the length of the longest suffix of the accepted bit history that equals a prefix of PATTERN, with k < PAT_LEN.
  - Accepted history = bits with en=1 since reset or since the last restart point.
  - k encodes in $clog2(PAT_LEN) bits. Illegal encodings (k >= PAT_LEN) return to 0 on the next edge.
- Next-state rule when en=1, with b = din:
  - If b extends the matched prefix (PATTERN bit [PAT_LEN-1-k] == b) and k+1 < PAT_LEN: k <= k+1.
  - If b extends the matched prefix and k+1 == PAT_LEN: this is a match event.
    - OVERLAP=1: k <= length of the longest proper border of PATTERN (e.g. 1 for 1011).
    - OVERLAP=0: k <= 0, and history restarts.
  - Otherwise (mismatch): k <= longest j < k+1 such that the last j bits of (history,b) equal the first j bits of PATTERN. This is the KMP failure fallback. Transitions may be computed by a generate-time table or a combinational history compare.
- When en=0: k holds, match=0, and the counter holds.
- match (Mealy output): match = en & ~rst & (k == PAT_LEN-1) & (din == PATTERN[0]).
  - Combinational, in the same cycle the final bit is presented.
  - Zero cycles of latency from the final bit.
- match_cnt:
  - Increments by 1 on the clock edge that ends a cycle with match=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - clr_cnt=1 forces 0 and beats a simultaneous increment: a match in the clear cycle is not counted.
  - The match output itself is unaffected by clr_cnt.
- prog = k, registered.
- Single clock domain. No multicycle paths. No latches: all combinational outputs are fully assigned, with defaults.

Optional Feature:
Macro MEALY_SEQ_DET_MATCH_REG_EN.
- When defined: match is a registered (Moore-style) output.
  - It is asserted in the cycle after the final bit is accepted, for exactly one cycle.
  - It is cleared by rst.
  - The counter increment timing is unchanged.
- When undefined: match is the combinational Mealy output described above.
- The feature must not change k, prog, or match_cnt behaviour.

Test Plan:
1. PATTERN=1011, OVERLAP=1, en=1, din stream 1,0,1,1,0,1,1 -> match=1 on bits 4 and 7 only; match_cnt=2 after bit 7; prog=1 after each match.
2. Same stream, OVERLAP=0 -> match only on bit 4; match_cnt=1. Stream 1,0,1,1,1,0,1,1 -> matches on bits 4 and 8.
3. Enable gaps: 1,(en=0,din=0),0,(en=0,din=1),1,1 -> match on the final bit. Bits presented with en=0 are ignored, and match stays 0 during gaps.
4. Reset mid-pattern: feed 1,0,1, assert rst for 1 cycle with din=1, then feed 1 -> no match; prog=0 after reset, then 1.
5. Saturation/clear with CNT_W=2: 4 overlapping matches -> match_cnt=3. Assert clr_cnt in a match cycle -> match=1, match_cnt=0 next cycle.
6. With MEALY_SEQ_DET_MATCH_REG_EN defined, rerun scenario 1 -> match is high on the cycles after bits 4 and 7, one cycle wide; match_cnt values are identical to scenario 1.
